det_seq_ctrl: RTL and testbench

- Frame sequencer for the single-bit sequence detectors (Mealy and Moore) in the npc top.
- Accepts a parallel frame over a valid/ready handshake and serialises it MSB-first onto the shared detector input `w`, one bit per clock.
- Counts detections reported by each detector and cross-checks them, aligning the Moore output one cycle later than the Mealy output.
- Reports per-frame results with a one-cycle `done` pulse.

---
 rtl/det_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_det_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/det_seq_ctrl.sv
// det_seq_ctrl: frame sequencer for the Mealy/Moore sequence detectors.
// Takes a parallel frame over in_valid/in_ready and shifts it out MSB-first on w.
// It counts the hits from each detector over the frame. The Moore output is
// compared with the Mealy output from one cycle earlier, and any disagreement
// sets the sticky mismatch flag.
// Ports:
//   clk, rst        - clock; asynchronous active-low reset
//   in_valid/ready  - frame handshake (ready only while idle)
//   in_data, in_len - frame bits (MSB first) and length (0 or >WIDTH means WIDTH)
//   abort           - cancel the frame during SHIFT/DRAIN
//   w               - serial bit to both detectors
//   z_melay/z_moore - detector outputs
//   busy, done      - frame in flight; one-cycle result-valid pulse
//   melay_cnt/moore_cnt/mismatch - per-frame results, held until next accept
module det_seq_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic             abort,
  output logic             w,
  input  logic             z_melay,
  input  logic             z_moore,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] melay_cnt,
  output logic [CNT_W-1:0] moore_cnt,
  output logic             mismatch
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] bitcnt_q, bitcnt_d;
  logic [LEN_W-1:0] len_eff;
  logic             first_q, first_d;
  logic             melay_d_q, melay_d_d;
  logic [CNT_W-1:0] melay_cnt_d, moore_cnt_d;
  logic             mismatch_d;
  logic             w_d, busy_d, done_d, in_ready_d;
  logic             moore_smp;

  // State and output registers; outputs are computed from next-state values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      first_q   <= 1'b0;
      melay_d_q <= 1'b0;
      melay_cnt <= '0;
      moore_cnt <= '0;
      mismatch  <= 1'b0;
      w         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      first_q   <= first_d;
      melay_d_q <= melay_d_d;
      melay_cnt <= melay_cnt_d;
      moore_cnt <= moore_cnt_d;
      mismatch  <= mismatch_d;
      w         <= w_d;
      busy      <= busy_d;
      done      <= done_d;
      in_ready  <= in_ready_d;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    first_d     = first_q;
    melay_d_d   = melay_d_q;
    melay_cnt_d = melay_cnt;
    moore_cnt_d = moore_cnt;
    mismatch_d  = mismatch;
    moore_smp   = 1'b0;

    // A length of 0 or one larger than the frame means a full frame.
    if (in_len == '0 || in_len > LEN_W'(WIDTH)) len_eff = LEN_W'(WIDTH);
    else                                         len_eff = in_len;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          shreg_d     = in_data;
          bitcnt_d    = len_eff;
          first_d     = 1'b1;
          melay_cnt_d = '0;
          moore_cnt_d = '0;
          mismatch_d  = 1'b0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d  = bitcnt_q - LEN_W'(1);
          first_d   = 1'b0;
          melay_d_d = z_melay;
          if (z_melay && melay_cnt != CNT_MAX) melay_cnt_d = melay_cnt + CNT_W'(1);
          // Moore lags Mealy by one cycle, so the first bit has nothing to compare.
          moore_smp = !first_q;
          if (bitcnt_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          moore_smp = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (moore_smp) begin
      if (z_moore && moore_cnt != CNT_MAX) moore_cnt_d = moore_cnt + CNT_W'(1);
      if (z_moore != melay_d_q)            mismatch_d  = 1'b1;
    end

    w_d        = (state_d == S_SHIFT) && shreg_d[WIDTH-1];
    busy_d     = (state_d == S_SHIFT) || (state_d == S_DRAIN);
    done_d     = (state_d == S_DONE);
    in_ready_d = (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_det_seq_ctrl.sv
// Directed bench for det_seq_ctrl. Detector outputs are stubbed per cycle.
// A second instance with CNT_W=2 covers counter saturation.
module tb_det_seq_ctrl;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned LEN_W = 5;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             abort = 1'b0;
  logic             z_melay = 1'b0;
  logic             z_moore = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [LEN_W-1:0] in_len = '0;

  logic             in_ready, w, busy, done, mismatch;
  logic [CNT_W-1:0] melay_cnt, moore_cnt;
  logic             s_in_ready, s_w, s_busy, s_done, s_mismatch;
  logic [1:0]       s_melay_cnt, s_moore_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] w_got;
  int          done_cyc, n_done;
  logic [63:0] busy_m;

  always #5 clk = ~clk;

  det_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .abort(abort), .w(w),
    .z_melay(z_melay), .z_moore(z_moore), .busy(busy), .done(done),
    .melay_cnt(melay_cnt), .moore_cnt(moore_cnt), .mismatch(mismatch)
  );

  det_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_len(in_len), .abort(abort), .w(s_w),
    .z_melay(z_melay), .z_moore(z_moore), .busy(s_busy), .done(s_done),
    .melay_cnt(s_melay_cnt), .moore_cnt(s_moore_cnt), .mismatch(s_mismatch)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 while idle. Cycle 0 is the accept cycle, and cycle c
  // follows the c-th edge after it. Mask bit c drives z in cycle c.
  task automatic run_frame(input logic [15:0] data, input logic [4:0] len,
                           input logic [63:0] mel_m, input logic [63:0] moo_m,
                           input int abort_at, input int nbits, input int maxc,
                           output logic [15:0] wg, output int dcyc, output int nd,
                           output logic [63:0] bm);
    wg = '0; dcyc = 0; nd = 0; bm = '0;
    in_data = data; in_len = len; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= maxc; c++) begin
      z_melay = mel_m[c];
      z_moore = moo_m[c];
      abort   = (abort_at == c);
      @(negedge clk);
      if (c <= nbits) wg = {wg[14:0], w};
      bm[c] = busy;
      if (done) begin
        nd++;
        if (dcyc == 0) dcyc = c;
      end
      @(posedge clk); #1;
    end
    z_melay = 1'b0; z_moore = 1'b0; abort = 1'b0;
  endtask

  initial begin
    // Reset held while a frame is offered.
    rst = 1'b0; in_valid = 1'b1; in_data = 16'hA5C3; in_len = 5'd16;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_w", w, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_counts", {melay_cnt, moore_cnt, mismatch}, 0);
    check("rst_small", {s_w, s_busy, s_done, s_mismatch, s_melay_cnt, s_moore_cnt}, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_in_ready_small", s_in_ready, 1);
    @(posedge clk); #1;

    // Serialise a full 16-bit frame with silent detectors.
    run_frame(16'hA5C3, 5'd16, 64'h0, 64'h0, 0, 16, 20, w_got, done_cyc, n_done, busy_m);
    check("ser_w", w_got, 16'hA5C3);
    check("ser_done_cyc", done_cyc, 18);
    check("ser_done_cnt", n_done, 1);
    check("ser_busy_c1", busy_m[1], 1);
    check("ser_busy_c17", busy_m[17], 1);
    check("ser_busy_c18", busy_m[18], 0);
    check("ser_counts", {melay_cnt, moore_cnt, mismatch}, 0);

    // Aligned detections: Mealy in cycle 3, Moore in cycle 4.
    run_frame(16'hB000, 5'd4, 64'h8, 64'h10, 0, 4, 8, w_got, done_cyc, n_done, busy_m);
    check("aln_w", w_got[3:0], 4'hB);
    check("aln_done_cyc", done_cyc, 6);
    check("aln_melay", melay_cnt, 1);
    check("aln_moore", moore_cnt, 1);
    check("aln_mismatch", mismatch, 0);

    // Moore pulse one cycle early gives a mismatch.
    run_frame(16'hB000, 5'd4, 64'h8, 64'h8, 0, 4, 8, w_got, done_cyc, n_done, busy_m);
    check("mis_melay", melay_cnt, 1);
    check("mis_moore", moore_cnt, 1);
    check("mis_mismatch", mismatch, 1);

    // A length of 0 sends the full frame.
    run_frame(16'h8001, 5'd0, 64'h0, 64'h0, 0, 16, 20, w_got, done_cyc, n_done, busy_m);
    check("len0_w", w_got, 16'h8001);
    check("len0_done_cyc", done_cyc, 18);
    check("len0_mismatch_cleared", mismatch, 0);

    // A length above WIDTH sends the full frame.
    run_frame(16'h4002, 5'd20, 64'h0, 64'h0, 0, 16, 20, w_got, done_cyc, n_done, busy_m);
    check("len20_w", w_got, 16'h4002);
    check("len20_done_cyc", done_cyc, 18);

    // A one-bit frame compares only in the DRAIN sample, which is cycle 2.
    run_frame(16'h8000, 5'd1, 64'h0, 64'h4, 0, 1, 5, w_got, done_cyc, n_done, busy_m);
    check("len1_w", w_got[0], 1);
    check("len1_done_cyc", done_cyc, 3);
    check("len1_moore", moore_cnt, 1);
    check("len1_melay", melay_cnt, 0);
    check("len1_mismatch", mismatch, 1);

    // Saturation: Mealy high in cycles 1-8 and Moore high in cycles 2-9.
    run_frame(16'h00FF, 5'd8, 64'h1FE, 64'h3FC, 0, 8, 12, w_got, done_cyc, n_done, busy_m);
    check("sat_melay_wide", melay_cnt, 8);
    check("sat_moore_wide", moore_cnt, 8);
    check("sat_melay_small", s_melay_cnt, 3);
    check("sat_moore_small", s_moore_cnt, 3);
    check("sat_mismatch", mismatch, 0);
    check("sat_done_small", s_done, 0);

    // Abort in cycle 5 after Mealy hits in cycles 1 and 3.
    run_frame(16'hFFFF, 5'd16, 64'hA, 64'h0, 5, 4, 20, w_got, done_cyc, n_done, busy_m);
    check("abt_no_done", n_done, 0);
    check("abt_busy_c5", busy_m[5], 1);
    check("abt_busy_c6", busy_m[6], 0);
    check("abt_melay", melay_cnt, 2);
    check("abt_in_ready", in_ready, 1);

    // The next frame is accepted cleanly with cleared results.
    run_frame(16'h4000, 5'd2, 64'h0, 64'h0, 0, 2, 6, w_got, done_cyc, n_done, busy_m);
    check("post_abt_w", w_got[1:0], 2'b01);
    check("post_abt_done_cyc", done_cyc, 4);
    check("post_abt_counts", {melay_cnt, moore_cnt, mismatch}, 0);

    // Asynchronous reset during a frame.
    in_data = 16'hFFFF; in_len = 5'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; z_melay = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("mid_pre_melay", melay_cnt, 3);
    check("mid_pre_w", w, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_w", w, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_melay", melay_cnt, 0);
    z_melay = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_in_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
